// File: rtl/mac_rx_frame_fifo_pkg.sv
// mac_rx_frame_fifo_pkg
//   Shared constants and types for the MAC RX store-and-forward frame FIFO.
//   N_SYMBOLS/W_SYMBOL/W_WORD : stream geometry (4 byte lanes, 32-bit data)
//   RX_FIFO_DEPTH             : default buffer depth in words
//   W_STAT_CNT                : width of the optional statistics counters
//   rx_fifo_state_t           : one-hot write-side FSM encoding
package mac_rx_frame_fifo_pkg;

  localparam int N_SYMBOLS     = 4;
  localparam int W_SYMBOL      = 8;
  localparam int W_WORD        = N_SYMBOLS * W_SYMBOL;
  localparam int RX_FIFO_DEPTH = 256;
  localparam int W_STAT_CNT    = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_WRITE = 3'b010,
    ST_DROP  = 3'b100
  } rx_fifo_state_t;

  // Saturating increment used by the statistics counters.
  function automatic logic [W_STAT_CNT-1:0] sat_inc(input logic [W_STAT_CNT-1:0] cnt,
                                                    input logic                  en);
    return (en && (cnt != {W_STAT_CNT{1'b1}})) ? cnt + W_STAT_CNT'(1) : cnt;
  endfunction

endpackage

// File: rtl/mac_rx_frame_fifo_if.sv
// mac_rx_frame_fifo_if
//   AXI-Stream bundle used on both sides of the RX frame FIFO.
//   tvalid/tready handshake, tkeep byte enables, tdata payload, tlast end of
//   frame, tuser frame error (meaningful with tlast).
//   master : drives the beat, receives tready
//   slave  : receives the beat, drives tready
interface mac_rx_frame_fifo_if;
  import mac_rx_frame_fifo_pkg::*;

  logic                 tvalid;
  logic                 tready;
  logic [N_SYMBOLS-1:0] tkeep;
  logic [W_WORD-1:0]    tdata;
  logic                 tlast;
  logic                 tuser;

  modport master (output tvalid, tkeep, tdata, tlast, tuser, input tready);
  modport slave  (input tvalid, tkeep, tdata, tlast, tuser, output tready);

endinterface

// File: rtl/mac_rx_frame_fifo_sdp_ram.sv
// mac_rx_frame_fifo_sdp_ram
//   Simple dual-port RAM: one write port, one read port with a registered
//   output that holds its value while i_re is low.
//   i_clk                      : clock
//   i_we / i_waddr / i_wdata   : write port
//   i_re / i_raddr / o_rdata   : read port (1-cycle latency)
module mac_rx_frame_fifo_sdp_ram #(
  parameter int W_ADDR = 8,
  parameter int W_DATA = 36
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [W_ADDR-1:0] i_waddr,
  input  logic [W_DATA-1:0] i_wdata,
  input  logic              i_re,
  input  logic [W_ADDR-1:0] i_raddr,
  output logic [W_DATA-1:0] o_rdata
);

  logic [W_DATA-1:0] mem_q [2**W_ADDR];
  logic [W_DATA-1:0] rdata_q;

  // Storage write and registered read; the read register holds when not enabled.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      rdata_q <= mem_q[i_raddr];
    end
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/mac_rx_frame_fifo.sv
// mac_rx_frame_fifo
//   Store-and-forward frame buffer behind the MAC RX stage. Frames are written
//   speculatively and committed only when they end cleanly; errored, overflowing
//   and empty frames are discarded by rewinding the write pointer. Committed
//   frames are streamed out with full backpressure.
//   i_clk, i_reset : clock, synchronous active-high reset
//   s_axis         : MAC RX stream in (no backpressure; tready tied high)
//   m_axis         : committed frames out (tuser tied low)
//   o_drop         : one-cycle pulse per discarded frame
//   Optional RX_FIFO_STATS_EN adds o_frame_cnt / o_err_cnt / o_ovf_cnt.
module mac_rx_frame_fifo
  import mac_rx_frame_fifo_pkg::*;
#(
  parameter int DEPTH = RX_FIFO_DEPTH
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  mac_rx_frame_fifo_if.slave    s_axis,
  mac_rx_frame_fifo_if.master   m_axis,
  output logic                  o_drop
`ifdef RX_FIFO_STATS_EN
  ,
  output logic [W_STAT_CNT-1:0] o_frame_cnt,
  output logic [W_STAT_CNT-1:0] o_err_cnt,
  output logic [W_STAT_CNT-1:0] o_ovf_cnt
`endif
);

  localparam int W_ADDR = $clog2(DEPTH);
  localparam int W_PTR  = W_ADDR + 1;
  localparam int W_RAM  = N_SYMBOLS + W_WORD;
  localparam logic [W_PTR-1:0] PTR_ONE   = W_PTR'(1);
  localparam logic [W_PTR-1:0] PTR_DEPTH = W_PTR'(DEPTH);

  rx_fifo_state_t    state_q, state_d;
  logic [W_PTR-1:0]  wr_ptr_q, wr_ptr_d, cmt_ptr_q, cmt_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0]  last_q, last_d;
  logic              ram_vld_q, ram_vld_d, ram_last_q, ram_last_d;
  logic              out_vld_q, out_vld_d, out_last_q, out_last_d;
  logic [W_RAM-1:0]  out_word_q, out_word_d;
  logic              drop_q, drop_d;

  logic              beat_s, keep_any_s, full_s;
  logic              wr_s, last_s, mark_s, commit_s, rewind_s, err_s, ovf_s;
  logic              rd_en_s, out_load_s;
  logic [W_ADDR-1:0] wr_idx_s, wr_prev_idx_s;
  logic [DEPTH-1:0]  wr_hot_s, mark_hot_s;
  logic [W_RAM-1:0]  ram_rdata_s;

  assign beat_s        = s_axis.tvalid;
  assign keep_any_s    = |s_axis.tkeep;
  assign full_s        = (wr_ptr_q - rd_ptr_q) == PTR_DEPTH;
  assign wr_idx_s      = wr_ptr_q[W_ADDR-1:0];
  assign wr_prev_idx_s = wr_ptr_q[W_ADDR-1:0] - W_ADDR'(1);

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and per-beat write-side decisions.
  always_comb begin
    state_d  = state_q;
    wr_s     = 1'b0;
    last_s   = 1'b0;
    mark_s   = 1'b0;
    commit_s = 1'b0;
    rewind_s = 1'b0;
    err_s    = 1'b0;
    ovf_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Beats with no enabled bytes carry nothing to store; a lone EOF beat
        // is an empty frame and is ignored.
        if (beat_s && keep_any_s) begin
          if (s_axis.tlast && s_axis.tuser) begin
            err_s = 1'b1;
          end else if (full_s) begin
            ovf_s   = 1'b1;
            state_d = s_axis.tlast ? ST_IDLE : ST_DROP;
          end else begin
            wr_s     = 1'b1;
            last_s   = s_axis.tlast;
            commit_s = s_axis.tlast;
            state_d  = s_axis.tlast ? ST_IDLE : ST_WRITE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (!beat_s) begin
          state_d = ST_WRITE;
        end else if (s_axis.tlast) begin
          state_d = ST_IDLE;
          if (s_axis.tuser) begin
            rewind_s = 1'b1;
            err_s    = 1'b1;
          end else if (!keep_any_s) begin
            // Trailing control-only EOF: flag the previous word as last.
            mark_s   = 1'b1;
            commit_s = 1'b1;
          end else if (full_s) begin
            rewind_s = 1'b1;
            ovf_s    = 1'b1;
          end else begin
            wr_s     = 1'b1;
            last_s   = 1'b1;
            commit_s = 1'b1;
          end
        end else if (!keep_any_s) begin
          state_d = ST_WRITE;
        end else if (full_s) begin
          // Rewind now so the space is free while the rest is discarded.
          rewind_s = 1'b1;
          ovf_s    = 1'b1;
          state_d  = ST_DROP;
        end else begin
          wr_s    = 1'b1;
          state_d = ST_WRITE;
        end
      end
      ST_DROP: begin
        state_d = (beat_s && s_axis.tlast) ? ST_IDLE : ST_DROP;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Write-side datapath: pointers, tlast flags, drop pulse.
  always_comb begin
    wr_hot_s   = {{(DEPTH-1){1'b0}}, wr_s} << wr_idx_s;
    mark_hot_s = {{(DEPTH-1){1'b0}}, mark_s} << wr_prev_idx_s;
    last_d     = (last_q & ~wr_hot_s) | (wr_hot_s & {DEPTH{last_s}}) | mark_hot_s;
    wr_ptr_d   = rewind_s ? cmt_ptr_q : (wr_s ? wr_ptr_q + PTR_ONE : wr_ptr_q);
    cmt_ptr_d  = commit_s ? (wr_s ? wr_ptr_q + PTR_ONE : wr_ptr_q) : cmt_ptr_q;
    drop_d     = err_s | ovf_s;
  end

  // Read side: RAM stage prefetches whenever it is empty or being drained into
  // the output register, giving one word per cycle at tready=1.
  always_comb begin
    out_load_s = ram_vld_q & (~out_vld_q | m_axis.tready);
    rd_en_s    = (rd_ptr_q != cmt_ptr_q) & (~ram_vld_q | out_load_s);
    rd_ptr_d   = rd_en_s ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    ram_last_d = rd_en_s ? last_q[rd_ptr_q[W_ADDR-1:0]] : ram_last_q;
    ram_vld_d  = rd_en_s ? 1'b1 : (out_load_s ? 1'b0 : ram_vld_q);
    out_vld_d  = out_load_s ? 1'b1 : (m_axis.tready ? 1'b0 : out_vld_q);
    out_last_d = out_load_s ? ram_last_q : (m_axis.tready ? 1'b0 : out_last_q);
    out_word_d = out_load_s ? ram_rdata_s : out_word_q;
  end

  // Datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_q   <= '0;
      cmt_ptr_q  <= '0;
      rd_ptr_q   <= '0;
      last_q     <= '0;
      ram_vld_q  <= 1'b0;
      ram_last_q <= 1'b0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
      out_word_q <= '0;
      drop_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      cmt_ptr_q  <= cmt_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      last_q     <= last_d;
      ram_vld_q  <= ram_vld_d;
      ram_last_q <= ram_last_d;
      out_vld_q  <= out_vld_d;
      out_last_q <= out_last_d;
      out_word_q <= out_word_d;
      drop_q     <= drop_d;
    end
  end

  mac_rx_frame_fifo_sdp_ram #(
    .W_ADDR (W_ADDR),
    .W_DATA (W_RAM)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (wr_s),
    .i_waddr (wr_idx_s),
    .i_wdata ({s_axis.tkeep, s_axis.tdata}),
    .i_re    (rd_en_s),
    .i_raddr (rd_ptr_q[W_ADDR-1:0]),
    .o_rdata (ram_rdata_s)
  );

  assign s_axis.tready = 1'b1;
  assign m_axis.tvalid = out_vld_q;
  assign m_axis.tkeep  = out_word_q[W_RAM-1 -: N_SYMBOLS];
  assign m_axis.tdata  = out_word_q[W_WORD-1:0];
  assign m_axis.tlast  = out_last_q;
  assign m_axis.tuser  = 1'b0;
  assign o_drop        = drop_q;

`ifdef RX_FIFO_STATS_EN
  logic [W_STAT_CNT-1:0] frame_cnt_q, frame_cnt_d, err_cnt_q, err_cnt_d, ovf_cnt_q, ovf_cnt_d;

  // Statistics next-state.
  always_comb begin
    frame_cnt_d = sat_inc(frame_cnt_q, commit_s);
    err_cnt_d   = sat_inc(err_cnt_q, err_s);
    ovf_cnt_d   = sat_inc(ovf_cnt_q, ovf_s);
  end

  // Statistics registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
      ovf_cnt_q   <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
      ovf_cnt_q   <= ovf_cnt_d;
    end
  end

  assign o_frame_cnt = frame_cnt_q;
  assign o_err_cnt   = err_cnt_q;
  assign o_ovf_cnt   = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_mac_rx_frame_fifo.sv
// tb_mac_rx_frame_fifo
//   Directed bench for mac_rx_frame_fifo (DEPTH=64). Frame words encode the
//   frame id in the top byte and the word index in the bottom byte.
module tb_mac_rx_frame_fifo;
  import mac_rx_frame_fifo_pkg::*;

  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic o_drop;
  always #5 clk = ~clk;

  mac_rx_frame_fifo_if s_if ();
  mac_rx_frame_fifo_if m_if ();

`ifdef RX_FIFO_STATS_EN
  logic [W_STAT_CNT-1:0] frame_cnt, err_cnt, ovf_cnt;
`endif

  mac_rx_frame_fifo #(.DEPTH(DEPTH)) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .s_axis (s_if),
    .m_axis (m_if),
    .o_drop (o_drop)
`ifdef RX_FIFO_STATS_EN
    ,
    .o_frame_cnt(frame_cnt),
    .o_err_cnt  (err_cnt),
    .o_ovf_cnt  (ovf_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic toggle_en = 1'b0;
  logic [36:0] got_q[$];
  logic [36:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word(input logic [7:0] id, input logic [7:0] idx);
    return {id, 16'h0000, idx};
  endfunction

  // Output monitor: records handshakes, checks hold-while-stalled and no gaps mid-frame.
  logic [36:0] cur_s;
  logic [36:0] prev_word = '0;
  logic prev_stall = 1'b0;
  logic mid_frame = 1'b0;
  int drop_cnt = 0;
  assign cur_s = {m_if.tlast, m_if.tkeep, m_if.tdata};

  always @(negedge clk) begin
    if (rst) begin
      prev_stall <= 1'b0;
      mid_frame  <= 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", m_if.tvalid, 1);
        chk("hold_word", cur_s, prev_word);
      end else if (mid_frame) begin
        chk("no_gap", m_if.tvalid, 1);
      end
      if (o_drop) drop_cnt <= drop_cnt + 1;
      if (m_if.tvalid && m_if.tready) begin
        got_q.push_back(cur_s);
        mid_frame <= !m_if.tlast;
      end
      prev_stall <= m_if.tvalid && !m_if.tready;
      prev_word  <= cur_s;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (toggle_en) m_if.tready = ~m_if.tready;
  endtask

  task automatic drive_beat(input logic [3:0] keep, input logic [31:0] data,
                            input logic last, input logic user);
    s_if.tvalid = 1'b1;
    s_if.tkeep  = keep;
    s_if.tdata  = data;
    s_if.tlast  = last;
    s_if.tuser  = user;
    tick();
  endtask

  task automatic idle(input int n);
    s_if.tvalid = 1'b0;
    s_if.tkeep  = 4'h0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
    repeat (n) tick();
  endtask

  // n full words; either tlast on the last word or a separate tkeep=0 EOF beat.
  task automatic send_frame(input logic [7:0] id, input int n, input logic eof_beat,
                            input logic user);
    for (int i = 0; i < n; i++) begin
      drive_beat(4'hF, word(id, 8'(i)), !eof_beat && (i == n - 1),
                 !eof_beat && (i == n - 1) && user);
    end
    if (eof_beat) drive_beat(4'h0, 32'h0, 1'b1, user);
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
  endtask

  task automatic push_exp(input logic [7:0] id, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), 4'hF, word(id, 8'(i))});
  endtask

  task automatic check_frames(input string tag, input int budget);
    int k;
    k = 0;
    while (got_q.size() < exp_q.size() && k < budget) begin
      tick();
      k++;
    end
    repeat (4) tick();
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) chk({tag, "_beat"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int d0;
    s_if.tvalid = 1'b0;
    s_if.tkeep  = 4'h0;
    s_if.tdata  = 32'h0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
    m_if.tready = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_tvalid", m_if.tvalid, 0);
    chk("rst_tlast", m_if.tlast, 0);
    chk("rst_drop", o_drop, 0);
    chk("s_tready", s_if.tready, 1);
    chk("m_tuser", m_if.tuser, 0);
    rst = 1'b0;
    tick();

    // 1: 16 words + control-only EOF beat; latency of 2 edges after the EOF edge.
    m_if.tready = 1'b1;
    d0 = drop_cnt;
    send_frame(8'h01, 16, 1'b1, 1'b0);
    chk("t1_lat0", m_if.tvalid, 0);
    tick();
    chk("t1_lat1", m_if.tvalid, 0);
    tick();
    chk("t1_lat2", m_if.tvalid, 1);
    chk("t1_first", m_if.tdata, word(8'h01, 8'h00));
    push_exp(8'h01, 16);
    check_frames("t1", 100);
    chk("t1_drop", drop_cnt - d0, 0);

    // 2: errored 10-word frame discarded, next 8-word frame intact.
    d0 = drop_cnt;
    send_frame(8'h02, 10, 1'b0, 1'b1);
    idle(6);
    chk("t2_drop", drop_cnt - d0, 1);
    chk("t2_none", got_q.size(), 0);
    chk("t2_tvalid", m_if.tvalid, 0);
    send_frame(8'h03, 8, 1'b0, 1'b0);
    push_exp(8'h03, 8);
    check_frames("t2", 100);

    // 3: tready low, 40-word frame committed, second 40-word frame overflows.
    m_if.tready = 1'b0;
    d0 = drop_cnt;
    send_frame(8'h04, 40, 1'b0, 1'b0);
    idle(4);
    chk("t3_stall_valid", m_if.tvalid, 1);
    chk("t3_stall_data", m_if.tdata, word(8'h04, 8'h00));
    send_frame(8'h05, 40, 1'b0, 1'b0);
    idle(4);
    chk("t3_drop", drop_cnt - d0, 1);
    chk("t3_none", got_q.size(), 0);
    push_exp(8'h04, 40);
    m_if.tready = 1'b1;
    check_frames("t3", 200);
`ifdef RX_FIFO_STATS_EN
    chk("stat_frames", frame_cnt, 3);
    chk("stat_err", err_cnt, 1);
    chk("stat_ovf", ovf_cnt, 1);
`endif

    // 4: lone empty EOF beat in idle is ignored silently.
    d0 = drop_cnt;
    drive_beat(4'h0, 32'h0, 1'b1, 1'b0);
    idle(6);
    chk("t4_drop", drop_cnt - d0, 0);
    chk("t4_none", got_q.size(), 0);
    chk("t4_tvalid", m_if.tvalid, 0);
    send_frame(8'h06, 4, 1'b1, 1'b0);
    push_exp(8'h06, 4);
    check_frames("t4", 100);

    // 5: tready toggling 1010 while a 20-word frame streams out.
    m_if.tready = 1'b1;
    toggle_en = 1'b1;
    send_frame(8'h07, 20, 1'b1, 1'b0);
    push_exp(8'h07, 20);
    check_frames("t5", 200);
    toggle_en = 1'b0;
    m_if.tready = 1'b1;

    // 6: reset on word 5 of 12 with a stalled committed frame at the output.
    m_if.tready = 1'b0;
    send_frame(8'h08, 3, 1'b0, 1'b0);
    idle(4);
    chk("t6_pre_valid", m_if.tvalid, 1);
    for (int i = 0; i < 4; i++) drive_beat(4'hF, word(8'h09, 8'(i)), 1'b0, 1'b0);
    s_if.tdata = word(8'h09, 8'h04);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_tvalid", m_if.tvalid, 0);
    chk("t6_tlast", m_if.tlast, 0);
    chk("t6_drop", o_drop, 0);
    m_if.tready = 1'b1;
    idle(6);
    chk("t6_empty", got_q.size(), 0);
    chk("t6_tvalid_idle", m_if.tvalid, 0);
    send_frame(8'h0A, 6, 1'b1, 1'b0);
    push_exp(8'h0A, 6);
    check_frames("t6", 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
